dig_pin_glitch_filter: RTL and testbench

- Digital glitch filter stage directly downstream of the pin synchronizer.
- Consumes the already-synchronized pin level and propagates a new level only after it has been stable for a programmable number of clk_i cycles.
- Generates a one-cycle edge event on selected filtered transitions.
- Its output is the level the pin-filter UVC checks against its own synchronized reference.

---
 rtl/dig_pin_glitch_filter.sv | 125 ++++++++++++
 tb/tb_dig_pin_glitch_filter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dig_pin_glitch_filter.sv
// Glitch filter behind the pin synchronizer: a new level reaches pin_filt_o only after
// it has been stable for filt_len_i cycles; selected filtered edges raise a one-cycle event.
module dig_pin_glitch_filter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             pin_sync_i,
  input  logic             filt_en_i,
  input  logic [CNT_W-1:0] filt_len_i,
  input  logic [1:0]       edge_sel_i,
  output logic             pin_filt_o,
  output logic             edge_evt_o,
  output logic             busy_o
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] LEN_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             pin_q, pin_d;
  logic             evt_q, evt_d;
  logic             busy_q, busy_d;

  logic             diff_s;
  logic [CNT_W:0]   cnt_inc_s;
  logic [CNT_W-1:0] len_eff_s;

  function automatic logic edge_match(input logic [1:0] sel, input logic new_lvl);
    case (sel)
      2'b01:   return new_lvl;
      2'b10:   return ~new_lvl;
      2'b11:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // One bit wider than the counter so the compare against len_q can never wrap.
  assign diff_s    = (pin_sync_i != pin_q);
  assign cnt_inc_s = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign len_eff_s = (filt_len_i == CNT_ZERO) ? LEN_ONE : filt_len_i;

  // Next-state, counter and filtered-level logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    pin_d   = pin_q;
    if (!filt_en_i) begin
      pin_d   = pin_sync_i;
      cnt_d   = CNT_ZERO;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (diff_s) begin
            len_d = len_eff_s;
            if (len_eff_s == LEN_ONE) begin
              pin_d = pin_sync_i;
              cnt_d = CNT_ZERO;
            end else begin
              cnt_d   = LEN_ONE;
              state_d = COUNT;
            end
          end else begin
            cnt_d = CNT_ZERO;
          end
        end
        COUNT: begin
          if (!diff_s) begin
            cnt_d   = CNT_ZERO;
            state_d = IDLE;
          end else if (cnt_inc_s == {1'b0, len_q}) begin
            pin_d   = pin_sync_i;
            cnt_d   = CNT_ZERO;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_inc_s[CNT_W-1:0];
          end
        end
        default: begin
          cnt_d   = CNT_ZERO;
          state_d = IDLE;
        end
      endcase
    end
  end

  // Event and busy flags are derived from the next state so they line up with pin_filt_o.
  always_comb begin
    evt_d  = (pin_d != pin_q) && edge_match(edge_sel_i, pin_d);
    busy_d = (state_d == COUNT);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      len_q   <= CNT_ZERO;
      pin_q   <= 1'b0;
      evt_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      pin_q   <= pin_d;
      evt_q   <= evt_d;
      busy_q  <= busy_d;
    end
  end

  assign pin_filt_o = pin_q;
  assign edge_evt_o = evt_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_dig_pin_glitch_filter.sv
// Directed self-checking bench for dig_pin_glitch_filter; each task drives one scenario
// and compares outputs sampled 1ns after the rising edge against hand-derived values.
module tb_dig_pin_glitch_filter;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic       pin_sync_i;
  logic       filt_en_i;
  logic [7:0] filt_len_i;
  logic [1:0] edge_sel_i;
  logic       pin_filt_o;
  logic       edge_evt_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;

  dig_pin_glitch_filter #(.CNT_W(8)) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .pin_sync_i (pin_sync_i),
    .filt_en_i  (filt_en_i),
    .filt_len_i (filt_len_i),
    .edge_sel_i (edge_sel_i),
    .pin_filt_o (pin_filt_o),
    .edge_evt_o (edge_evt_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0; pin_sync_i = 1'b0; filt_en_i = 1'b1;
    filt_len_i = 8'd4; edge_sel_i = 2'b01;
    #2;
    checks++;
    if ({pin_filt_o, edge_evt_o, busy_o} !== 3'b000) begin
      errors++; $display("FAIL reset_outputs: got %b expected 000", {pin_filt_o, edge_evt_o, busy_o});
    end
    step(); step();
    rstn_i = 1'b1;
    step();
    checks++;
    if ({pin_filt_o, edge_evt_o, busy_o} !== 3'b000) begin
      errors++; $display("FAIL reset_idle: got %b expected 000", {pin_filt_o, edge_evt_o, busy_o});
    end
  endtask

  task automatic test_glitch();
    filt_len_i = 8'd4; edge_sel_i = 2'b01; pin_sync_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if ({pin_filt_o, edge_evt_o, busy_o} !== 3'b001) begin
        errors++; $display("FAIL glitch_count%0d: got %b expected 001", i, {pin_filt_o, edge_evt_o, busy_o});
      end
    end
    pin_sync_i = 1'b0;
    step();
    checks++;
    if ({pin_filt_o, edge_evt_o, busy_o} !== 3'b000) begin
      errors++; $display("FAIL glitch_drop: got %b expected 000", {pin_filt_o, edge_evt_o, busy_o});
    end
    step();
  endtask

  task automatic test_rise();
    filt_len_i = 8'd4; edge_sel_i = 2'b01; pin_sync_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      logic [2:0] exp;
      step();
      exp = (i < 4) ? 3'b001 : ((i == 4) ? 3'b110 : 3'b100);
      checks++;
      if ({pin_filt_o, edge_evt_o, busy_o} !== exp) begin
        errors++; $display("FAIL rise_edge%0d: got %b expected %b", i, {pin_filt_o, edge_evt_o, busy_o}, exp);
      end
    end
    // Falling transition must not raise an event when only rising is selected.
    pin_sync_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      logic [2:0] exp;
      step();
      exp = (i < 4) ? 3'b101 : 3'b000;
      checks++;
      if ({pin_filt_o, edge_evt_o, busy_o} !== exp) begin
        errors++; $display("FAIL fall_nosel%0d: got %b expected %b", i, {pin_filt_o, edge_evt_o, busy_o}, exp);
      end
    end
  endtask

  task automatic test_len01();
    edge_sel_i = 2'b11;
    for (int l = 0; l <= 1; l++) begin
      filt_len_i = l[7:0];
      pin_sync_i = 1'b1;
      step();
      checks++;
      if ({pin_filt_o, edge_evt_o, busy_o} !== 3'b110) begin
        errors++; $display("FAIL len%0d_rise: got %b expected 110", l, {pin_filt_o, edge_evt_o, busy_o});
      end
      pin_sync_i = 1'b0;
      step();
      checks++;
      if ({pin_filt_o, edge_evt_o, busy_o} !== 3'b010) begin
        errors++; $display("FAIL len%0d_fall: got %b expected 010", l, {pin_filt_o, edge_evt_o, busy_o});
      end
      step();
      checks++;
      if ({pin_filt_o, edge_evt_o, busy_o} !== 3'b000) begin
        errors++; $display("FAIL len%0d_settle: got %b expected 000", l, {pin_filt_o, edge_evt_o, busy_o});
      end
    end
  endtask

  task automatic test_bypass();
    logic [3:0] pat;
    logic [3:0] exp_evt;
    pat = 4'b1010;     // applied MSB first: 1,0,1,0
    exp_evt = 4'b0101; // events only on the 1->0 steps
    filt_en_i = 1'b0; edge_sel_i = 2'b10; filt_len_i = 8'd4;
    for (int i = 3; i >= 0; i--) begin
      pin_sync_i = pat[i];
      step();
      checks++;
      if ({pin_filt_o, edge_evt_o, busy_o} !== {pat[i], exp_evt[i], 1'b0}) begin
        errors++; $display("FAIL bypass%0d: got %b expected %b", 3 - i, {pin_filt_o, edge_evt_o, busy_o}, {pat[i], exp_evt[i], 1'b0});
      end
    end
    filt_en_i = 1'b1;
    step();
  endtask

  task automatic test_abort();
    filt_len_i = 8'd4; edge_sel_i = 2'b01; pin_sync_i = 1'b1;
    step();
    checks++;
    if ({pin_filt_o, edge_evt_o, busy_o} !== 3'b001) begin
      errors++; $display("FAIL abort_count: got %b expected 001", {pin_filt_o, edge_evt_o, busy_o});
    end
    filt_en_i = 1'b0;
    step();
    checks++;
    if ({pin_filt_o, edge_evt_o, busy_o} !== 3'b110) begin
      errors++; $display("FAIL abort_bypass: got %b expected 110", {pin_filt_o, edge_evt_o, busy_o});
    end
    pin_sync_i = 1'b0;
    step();
    filt_en_i = 1'b1;
    step();
  endtask

  task automatic test_reset_mid();
    filt_len_i = 8'd8; edge_sel_i = 2'b01; pin_sync_i = 1'b1;
    for (int i = 1; i <= 5; i++) step();
    checks++;
    if ({pin_filt_o, edge_evt_o, busy_o} !== 3'b001) begin
      errors++; $display("FAIL rstmid_busy: got %b expected 001", {pin_filt_o, edge_evt_o, busy_o});
    end
    rstn_i = 1'b0;
    #1;
    checks++;
    if ({pin_filt_o, edge_evt_o, busy_o} !== 3'b000) begin
      errors++; $display("FAIL rstmid_async: got %b expected 000", {pin_filt_o, edge_evt_o, busy_o});
    end
    step();
    rstn_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      logic [2:0] exp;
      step();
      exp = (i < 8) ? 3'b001 : 3'b110;
      checks++;
      if ({pin_filt_o, edge_evt_o, busy_o} !== exp) begin
        errors++; $display("FAIL rstmid_edge%0d: got %b expected %b", i, {pin_filt_o, edge_evt_o, busy_o}, exp);
      end
    end
  endtask

  task automatic test_long();
    filt_len_i = 8'd1; pin_sync_i = 1'b0;
    step();
    checks++;
    if (pin_filt_o !== 1'b0) begin
      errors++; $display("FAIL long_prep: got %b expected 0", pin_filt_o);
    end
    filt_len_i = 8'd255; edge_sel_i = 2'b01; pin_sync_i = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      step();
      if (i == 2) filt_len_i = 8'd2;
      if (i == 3 || i == 254) begin
        checks++;
        if ({pin_filt_o, edge_evt_o, busy_o} !== 3'b001) begin
          errors++; $display("FAIL long_edge%0d: got %b expected 001", i, {pin_filt_o, edge_evt_o, busy_o});
        end
      end
      if (i == 255) begin
        checks++;
        if ({pin_filt_o, edge_evt_o, busy_o} !== 3'b110) begin
          errors++; $display("FAIL long_edge255: got %b expected 110", {pin_filt_o, edge_evt_o, busy_o});
        end
      end
      if (i == 256) begin
        checks++;
        if ({pin_filt_o, edge_evt_o, busy_o} !== 3'b100) begin
          errors++; $display("FAIL long_after: got %b expected 100", {pin_filt_o, edge_evt_o, busy_o});
        end
      end
    end
  endtask

  task automatic test_sel_update();
    filt_len_i = 8'd2; edge_sel_i = 2'b00; pin_sync_i = 1'b0;
    step();
    checks++;
    if ({pin_filt_o, edge_evt_o, busy_o} !== 3'b101) begin
      errors++; $display("FAIL selupd_count: got %b expected 101", {pin_filt_o, edge_evt_o, busy_o});
    end
    edge_sel_i = 2'b10;
    step();
    checks++;
    if ({pin_filt_o, edge_evt_o, busy_o} !== 3'b010) begin
      errors++; $display("FAIL selupd_evt: got %b expected 010", {pin_filt_o, edge_evt_o, busy_o});
    end
    step();
    checks++;
    if (edge_evt_o !== 1'b0) begin
      errors++; $display("FAIL selupd_pulse: got %b expected 0", edge_evt_o);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_rise();
    test_len01();
    test_bypass();
    test_abort();
    test_reset_mid();
    test_long();
    test_sel_update();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
